// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide type definitions shared across the datapath.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath types for the branch target buffer: entry layout and default geometry.
package dp_types_pkg;

  import cpu_types_pkg::*;

  localparam int BTB_SETS      = 16;
  localparam int BTB_WAYS      = 2;
  localparam int BTB_CNT_W     = 2;

  // Widest tag (SETS=2 leaves 29 bits) and widest counter any configuration needs;
  // narrower configurations use the low bits and leave the rest at zero.
  localparam int BTB_TAG_MAX_W = 29;
  localparam int BTB_CNT_MAX_W = 4;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [BTB_CNT_MAX_W-1:0] counter;
    word_t                    target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down step for a branch-direction counter.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] value,
  input  logic             inc,
  output logic [CNT_W-1:0] next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Step toward taken or not-taken, holding at either end of the range.
  always_comb begin
    next = value;
    if (inc) begin
      if (value != CNT_MAX) next = value + CNT_W'(1);
    end else begin
      if (value != '0) next = value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/set_assoc_btb.sv
// Set-associative branch target buffer with per-entry direction counters,
// zero-latency lookup and a per-set round-robin replacement pointer.
module set_assoc_btb
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int SETS  = BTB_SETS,
  parameter int WAYS  = BTB_WAYS,
  parameter int CNT_W = BTB_CNT_W
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t rd_pc,
  output logic  rd_hit,
  output logic  rd_taken,
  output word_t rd_target,
  input  logic  wr_en,
  input  word_t wr_pc,
  input  logic  wr_taken,
  input  word_t wr_target,
  input  logic  flush
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Freshly allocated entries start just either side of the taken threshold.
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

  btb_entry_t       entries_q [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q     [SETS];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  logic             wr_hit;
  logic [WAY_W-1:0] wr_hit_way;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             any_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] ptr_next;

  // The byte offset within a word never distinguishes branches.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[31:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[31:IDX_W+2];

  // Fetch-side lookup; scanning downward leaves the lowest matching way in effect.
  always_comb begin
    rd_hit    = 1'b0;
    rd_taken  = 1'b0;
    rd_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entries_q[rd_idx][w].valid &&
          entries_q[rd_idx][w].tag[TAG_W-1:0] == rd_tag) begin
        rd_hit    = 1'b1;
        rd_taken  = entries_q[rd_idx][w].counter[CNT_W-1];
        rd_target = entries_q[rd_idx][w].target;
      end
    end
  end

  // Update-side lookup: matching way, its counter, and the lowest free way.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    wr_cnt     = '0;
    any_free   = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entries_q[wr_idx][w].valid &&
          entries_q[wr_idx][w].tag[TAG_W-1:0] == wr_tag) begin
        wr_hit     = 1'b1;
        wr_hit_way = WAY_W'(w);
        wr_cnt     = entries_q[wr_idx][w].counter[CNT_W-1:0];
      end
      if (!entries_q[wr_idx][w].valid) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = any_free ? free_way : ptr_q[wr_idx];
  assign ptr_next   = (WAYS == 1) ? '0 : ptr_q[wr_idx] + WAY_W'(1);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .value (wr_cnt),
    .inc   (wr_taken),
    .next  (cnt_next)
  );

  // Table state: reset clears everything, flush drops validity, updates train or allocate.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          entries_q[s][w] <= '0;
        end
        ptr_q[s] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          entries_q[s][w].valid <= 1'b0;
        end
        ptr_q[s] <= '0;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        entries_q[wr_idx][wr_hit_way].counter <= BTB_CNT_MAX_W'(cnt_next);
        if (wr_taken) entries_q[wr_idx][wr_hit_way].target <= wr_target;
      end else begin
        entries_q[wr_idx][victim_way] <= '{
          valid:   1'b1,
          tag:     BTB_TAG_MAX_W'(wr_tag),
          counter: BTB_CNT_MAX_W'(wr_taken ? CNT_WEAK_T : CNT_WEAK_NT),
          target:  wr_target
        };
        if (!any_free) ptr_q[wr_idx] <= ptr_next;
      end
    end
  end

endmodule
